// File: rtl/ctrl_pipe_if.sv
// Bundle of the ID-side inputs and the pipelined control outputs of ctrl_pipe.
// pc_bus and exc_vec give the datapath the per-stage PC+2 (for link writes) and the trap target.
interface ctrl_pipe_if #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 3
);
  localparam int CW = 25;

  logic                  id_valid;
  logic [4:0]            id_opcode;
  logic [PC_W-1:0]       id_pc_inc;
  logic                  stall;
  logic                  flush;
  logic                  ex_zflag;
  logic                  ex_sflag;
  logic [DEPTH*CW-1:0]   ctrl_bus;
  logic [DEPTH*PC_W-1:0] pc_bus;
  logic                  redirect;
  logic [1:0]            redirect_src;
  logic [PC_W-1:0]       epc;
  logic [PC_W-1:0]       exc_vec;
  logic                  in_exc;
  logic                  halt_req;
  logic                  halted;

  modport master (
    output id_valid, id_opcode, id_pc_inc, stall, flush, ex_zflag, ex_sflag,
    input  ctrl_bus, pc_bus, redirect, redirect_src, epc, exc_vec, in_exc, halt_req, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_pc_inc, stall, flush, ex_zflag, ex_sflag,
    output ctrl_bus, pc_bus, redirect, redirect_src, epc, exc_vec, in_exc, halt_req, halted
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined control decoder: decodes the ID opcode, carries the control bundle and PC+2
// through DEPTH stages, resolves control transfers in stage 0 (EX) and tracks EPC/halt.
module ctrl_pipe #(
  parameter int              PC_W    = 16,
  parameter int              DEPTH   = 3,
  parameter logic [PC_W-1:0] EXC_VEC = 16'h0002
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_pipe_if.slave bus
);
  localparam int CW = 25;

  logic [CW-1:0]   st_q [DEPTH];
  logic [CW-1:0]   st_d [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] pc_d [DEPTH];
  logic [PC_W-1:0] epc_q, epc_d;
  logic            in_exc_q, in_exc_d;
  logic            halted_q, halted_d;

  logic [CW-1:0]   dec;
  logic [4:0]      op;
  logic            load;
  logic            redir;
  logic [1:0]      src;
  logic            taken;
  logic            halt_req;
  logic            v0;

  assign op = bus.id_opcode;
  assign v0 = st_q[0][19];

  always_comb begin
    dec        = '0;
    dec[24:20] = op;
    dec[19]    = 1'b1;
    casez (op)
      5'b000??: begin
        dec[6] = (op[1:0] == 2'b00);
        dec[5] = (op[1:0] == 2'b10);
        dec[4] = (op[1:0] == 2'b11);
      end
      5'b001??: begin
        dec[18]    = op[1];
        dec[17:16] = 2'b10;
        dec[8:7]   = 2'b10;
        dec[11:9]  = op[0] ? 3'b101 : 3'b110;
        dec[3]     = ~op[0];
        dec[2]     = op[0];
      end
      5'b010??, 5'b101??: begin
        dec[18]    = 1'b1;
        dec[17:16] = 2'b11;
        dec[12]    = 1'b1;
        dec[11:9]  = op[1] ? 3'b000 : 3'b100;
      end
      5'b011??: begin
        dec[1]    = 1'b1;
        dec[11:9] = 3'b101;
      end
      5'b10000: begin
        dec[24:20] = 5'b01000;
        dec[15]    = 1'b1;
        dec[14]    = 1'b1;
        dec[12]    = 1'b1;
        dec[11:9]  = 3'b100;
      end
      5'b10001: begin
        dec[24:20] = 5'b01000;
        dec[18]    = 1'b1;
        dec[17:16] = 2'b11;
        dec[15]    = 1'b1;
        dec[13]    = 1'b1;
        dec[12]    = 1'b1;
        dec[11:9]  = 3'b100;
      end
      5'b10011: begin
        dec[24:20] = 5'b01000;
        dec[18]    = 1'b1;
        dec[15]    = 1'b1;
        dec[14]    = 1'b1;
        dec[12]    = 1'b1;
        dec[11:9]  = 3'b100;
      end
      5'b10010, 5'b11000: begin
        dec[18]   = 1'b1;
        dec[12]   = 1'b1;
        dec[11:9] = op[3] ? 3'b101 : 3'b001;
        dec[8:7]  = 2'b01;
      end
      5'b11001, 5'b1101?, 5'b111??: begin
        dec[18]    = 1'b1;
        dec[17:16] = 2'b01;
      end
      default: ;
    endcase
  end

  // Branch condition comes from the opcode's low bits, kept in ALUcntrl for branches.
  always_comb begin
    case (st_q[0][21:20])
      2'b00:   taken = bus.ex_zflag;
      2'b01:   taken = ~bus.ex_zflag;
      2'b10:   taken = bus.ex_sflag;
      default: taken = ~bus.ex_sflag;
    endcase
    redir = v0 & (st_q[0][3] | st_q[0][2] | (st_q[0][1] & taken) | st_q[0][5] | st_q[0][4]);
    src   = 2'b00;
    if (v0 && st_q[0][5])      src = 2'b01;
    else if (v0 && st_q[0][4]) src = 2'b10;
  end

  always_comb begin
    halt_req = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      halt_req = halt_req | (st_q[k][19] & st_q[k][6]);
    end
  end

  // halted also gates the load so nothing new enters once HALT has retired.
  assign load = bus.id_valid & ~bus.stall & ~bus.flush & ~redir & ~halt_req & ~halted_q;

  always_comb begin
    st_d[0] = load ? dec : '0;
    pc_d[0] = load ? bus.id_pc_inc : '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      st_d[k] = st_q[k-1];
      pc_d[k] = pc_q[k-1];
    end
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    if (v0 && st_q[0][5]) begin
      epc_d    = pc_q[0];
      in_exc_d = 1'b1;
    end else if (v0 && st_q[0][4]) begin
      in_exc_d = 1'b0;
    end
    halted_d = halted_q | (st_q[DEPTH-1][19] & st_q[DEPTH-1][6]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= '{default: '0};
      pc_q     <= '{default: '0};
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      halted_q <= halted_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bus.ctrl_bus[g*CW +: CW]   = st_q[g];
    assign bus.pc_bus[g*PC_W +: PC_W] = pc_q[g];
  end

  assign bus.redirect     = redir;
  assign bus.redirect_src = src;
  assign bus.epc          = epc_q;
  assign bus.exc_vec      = EXC_VEC;
  assign bus.in_exc       = in_exc_q;
  assign bus.halt_req     = halt_req;
  assign bus.halted       = halted_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with DEPTH=3: decode, stall/flush, redirect, EPC and halt.
module tb_ctrl_pipe;
  localparam int CW = 25;

  localparam logic [CW-1:0] ADD_B  = {5'b11011, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
                                      3'b000, 2'b00, 7'b0};
  localparam logic [CW-1:0] ADDI_B = {5'b01000, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1,
                                      3'b100, 2'b00, 7'b0};
  localparam logic [CW-1:0] LD_B   = {5'b01000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1,
                                      3'b100, 2'b00, 7'b0};

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [CW-1:0] s;

  ctrl_pipe_if #(.PC_W(16), .DEPTH(3)) bus ();

  ctrl_pipe #(.PC_W(16), .DEPTH(3), .EXC_VEC(16'h0002)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] pc);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_pc_inc = pc;
  endtask

  function automatic logic [CW-1:0] stg(input int k);
    return bus.ctrl_bus[k*CW +: CW];
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 16'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.ex_zflag = 1'b0;
    bus.ex_sflag = 1'b0;
    step();
    step();
    check("rst_ctrl_bus", bus.ctrl_bus, 0);
    check("rst_epc", bus.epc, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_redirect", bus.redirect, 0);
    check("rst_src", bus.redirect_src, 0);
    check("rst_halt_req", bus.halt_req, 0);
    check("rst_in_exc", bus.in_exc, 0);
    rst_n = 1'b1;

    // R-type ADD travelling through the pipe
    drive(1'b1, 5'b11011, 16'h0010);
    step();
    drive(1'b0, 5'd0, 16'h0);
    s = stg(0);
    check("add_s0_bundle", s, ADD_B);
    check("add_s0_regwrite", s[18], 1);
    check("add_s0_dest", s[17:16], 2'b01);
    check("add_s0_alusel", s[12], 0);
    step();
    step();
    check("add_s2_bundle", stg(2), ADD_B);
    check("add_s1_bubble", stg(1), 0);
    check("add_s2_pc", bus.pc_bus[2*16 +: 16], 16'h0010);

    // BEQZ taken kills the next ID instruction
    drive(1'b1, 5'b01100, 16'h0020);
    step();
    drive(1'b1, 5'b01000, 16'h0022);
    bus.ex_zflag = 1'b1;
    #1;
    check("beqz_taken_redirect", bus.redirect, 1);
    check("beqz_taken_src", bus.redirect_src, 2'b00);
    step();
    check("beqz_taken_kill", stg(0), 0);
    bus.ex_zflag = 1'b0;
    drive(1'b1, 5'b01100, 16'h0024);
    step();
    drive(1'b1, 5'b01000, 16'h0026);
    #1;
    check("beqz_nt_redirect", bus.redirect, 0);
    step();
    check("beqz_nt_next_loaded", stg(0), ADDI_B);
    // BLTZ with S=1 takes
    drive(1'b1, 5'b01110, 16'h0028);
    step();
    drive(1'b0, 5'd0, 16'h0);
    bus.ex_sflag = 1'b1;
    #1;
    check("bltz_redirect", bus.redirect, 1);
    bus.ex_sflag = 1'b0;
    step();

    // JAL
    drive(1'b1, 5'b00110, 16'h0030);
    step();
    drive(1'b0, 5'd0, 16'h0);
    s = stg(0);
    check("jal_redirect", bus.redirect, 1);
    check("jal_src", bus.redirect_src, 2'b00);
    check("jal_regwrite", s[18], 1);
    check("jal_dest", s[17:16], 2'b10);
    check("jal_link", s[8:7], 2'b10);
    step();

    // SIIC then RTI
    drive(1'b1, 5'b00010, 16'h0040);
    step();
    drive(1'b0, 5'd0, 16'h0);
    check("siic_redirect", bus.redirect, 1);
    check("siic_src", bus.redirect_src, 2'b01);
    step();
    check("siic_epc", bus.epc, 16'h0040);
    check("siic_in_exc", bus.in_exc, 1);
    check("siic_exc_vec", bus.exc_vec, 16'h0002);
    drive(1'b1, 5'b00011, 16'h0042);
    step();
    drive(1'b0, 5'd0, 16'h0);
    check("rti_redirect", bus.redirect, 1);
    check("rti_src", bus.redirect_src, 2'b10);
    step();
    check("rti_in_exc", bus.in_exc, 0);
    check("rti_epc_kept", bus.epc, 16'h0040);

    // Stall bubbles stage 0 while older stages advance
    drive(1'b1, 5'b01000, 16'h0050);
    step();
    drive(1'b1, 5'b10001, 16'h0052);
    bus.stall = 1'b1;
    step();
    check("stall_s0_bubble", stg(0), 0);
    check("stall_s1_addi", stg(1), ADDI_B);
    bus.stall = 1'b0;
    step();
    check("ld_s0_bundle", stg(0), LD_B);
    check("ld_s2_addi", stg(2), ADDI_B);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    check("stall_flush_bubble", stg(0), 0);
    check("stall_flush_noredir", bus.redirect, 0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Fill with ADDI, then async reset mid-cycle
    drive(1'b1, 5'b01000, 16'h0060);
    step();
    step();
    step();
    check("fill_s0", stg(0), ADDI_B);
    check("fill_s2", stg(2), ADDI_B);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl_bus", bus.ctrl_bus, 0);
    check("async_rst_epc", bus.epc, 0);
    check("async_rst_halted", bus.halted, 0);
    step();
    check("async_rst_hold", bus.ctrl_bus, 0);
    rst_n = 1'b1;

    // HALT: halt_req while in flight, then sticky halted
    drive(1'b1, 5'b00000, 16'h0070);
    step();
    drive(1'b1, 5'b01000, 16'h0072);
    s = stg(0);
    check("halt_s0_halt", s[6], 1);
    check("halt_req_c1", bus.halt_req, 1);
    step();
    check("halt_req_c2", bus.halt_req, 1);
    check("halt_c2_s0_blocked", stg(0), 0);
    step();
    s = stg(2);
    check("halt_req_c3", bus.halt_req, 1);
    check("halt_s2_halt", s[6], 1);
    check("halted_c3", bus.halted, 0);
    step();
    check("halted_c4", bus.halted, 1);
    check("halt_req_c4", bus.halt_req, 0);
    check("halted_s0_ignored", stg(0), 0);
    step();
    check("halted_still_ignored", stg(0), 0);
    check("halted_sticky", bus.halted, 1);
    rst_n = 1'b0;
    #1;
    check("halted_cleared", bus.halted, 0);
    step();
    rst_n = 1'b1;
    step();
    check("after_reset_accepts", stg(0), ADDI_B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
